pong_referee: RTL and testbench
===============================

PONG_REFEREE -- requirements
Module: pong_referee

Interface
REQ-001 SHALL have parameter XSCREEN, default 160: right-edge X coordinate where player 2 defends.
REQ-002 SHALL have parameter PADDLE_LEN, default 25: paddle height in pixels.
REQ-003 SHALL have parameter BALL_SIZE, default 5: ball height in pixels.
REQ-004 SHALL have parameter SCORE_W, default 4: score counter width.
REQ-005 SHALL have parameter WIN_SCORE, default 9: points needed to win; 1 <= WIN_SCORE <= 2^SCORE_W-1.
REQ-006 SHALL have parameter HOLD_CYC, default 50000000: POINT-state dwell in cycles; must be >= 1; counter is 32 bits.
REQ-007 Ports, clock and reset first:
- CLOCK_50 in 1: the single clock.
- Resetn in 1: synchronous, active-low reset.
- X in 8: ball left X.
- Y in 7: ball top Y.
- Y1 in 7: left paddle top Y.
- Y2 in 7: right paddle top Y.
- new_game in 1: clears scores and restarts play.
- miss1 out 1: one-cycle pulse, player 1 missed.
- miss2 out 1: one-cycle pulse, player 2 missed.
- score1 out SCORE_W: player 1 points.
- score2 out SCORE_W: player 2 points.
- serve out 1: one-cycle pulse requesting a ball re-serve.
- game_over out 1: level, match decided.
- winner out 1: 0 = player 1, 1 = player 2; valid while game_over=1.

Function
REQ-008 SHALL implement FSM states PLAY, POINT and OVER.
REQ-009 SHALL register X as x_prev every cycle; left event = (X==0 && x_prev!=0); right event = (X==XSCREEN && x_prev!=XSCREEN), so a held edge position yields one event only.
REQ-010 SHALL compute overlap with 8-bit unsigned arithmetic, no wrap: Y+BALL_SIZE > Yp && Y < Yp+PADDLE_LEN (Yp = Y1 for the left edge, Y2 for the right).
REQ-011 In PLAY, on a left event without Y1 overlap: miss1=1 and score2 += 1 on the next edge (latency 1 cycle); right event without Y2 overlap is symmetric (miss2, score1).
REQ-012 An event with overlap SHALL be a hit: no score change, FSM stays in PLAY.
REQ-013 After a miss: if the incremented score == WIN_SCORE, go to OVER with game_over=1 and winner set to the scorer; otherwise go to POINT with the counter loaded with HOLD_CYC-1.
REQ-014 POINT SHALL decrement the counter each cycle, ignore edge events, and at count 0 pulse serve for one cycle and return to PLAY.
REQ-015 OVER SHALL hold scores, game_over and winner, and ignore edge events until new_game.
REQ-016 new_game=1 in any state SHALL, on the next edge, clear scores, game_over, winner, counter, miss and serve, and enter PLAY; it has priority over a coincident edge event.
REQ-017 Scores SHALL never exceed WIN_SCORE and never wrap.
REQ-018 If left and right events coincide (only possible when XSCREEN==0), the left event SHALL be processed and the right event dropped.

Reset
REQ-019 While Resetn=0 at a CLOCK_50 edge: state=PLAY, x_prev=0, counter=0, and all outputs 0; reset mid-POINT or mid-OVER aborts immediately.
REQ-020 Reset SHALL take priority over new_game.

Configuration
REQ-021 With macro PADDLE_HIT_EN defined, output ports hit1 and hit2 (1 bit each) SHALL exist and pulse for one cycle, latency 1, on left and right hit events in PLAY; both reset to 0.
REQ-022 Without PADDLE_HIT_EN, hit1 and hit2 and their logic SHALL be absent; all other behaviour is identical.

Verification (HOLD_CYC=4, WIN_SCORE=3, SCORE_W=4)
REQ-023 Y=50, Y1=10, X 5->0: miss1 high exactly 1 cycle, score2=1, serve pulses 4 cycles after the state enters POINT.
REQ-024 Y=20, Y1=10, X 5->0 held 10 cycles: no miss1, scores unchanged, hit1 single pulse when PADDLE_HIT_EN is defined.
REQ-025 Three right-edge misses (Y=100, Y2=0, X=160): score1 reaches 3, game_over=1, winner=0; further events are ignored; new_game returns scores to 0 and game_over to 0.
REQ-026 Resetn=0 during POINT with score2=2: next cycle all outputs 0; serve never pulses.
REQ-027 Boundary overlap: Y1=10, Y=5 (Y+5=10, not > 10) -> miss1; Y=34 (< 35) -> hit; Y=35 -> miss1.

Source files
------------

// File: rtl/pong_referee.sv
// -----------------------------------------------------------------------------
// pong_referee
// Referee for a two-player Pong game. It watches the ball's X position for
// edge crossings, decides hit or miss against the defending paddle, keeps
// score, pauses play between points, and declares a winner.
//
// Ports:
//   CLOCK_50   in   single system clock
//   Resetn     in   synchronous active-low reset
//   X          in   ball left X coordinate (8 bits)
//   Y          in   ball top Y coordinate (7 bits)
//   Y1         in   left paddle top Y (player 1)
//   Y2         in   right paddle top Y (player 2)
//   new_game   in   clears scores and restarts play
//   miss1      out  one-cycle pulse, player 1 missed
//   miss2      out  one-cycle pulse, player 2 missed
//   score1     out  player 1 points
//   score2     out  player 2 points
//   serve      out  one-cycle pulse requesting a ball re-serve
//   game_over  out  level, match decided
//   winner     out  0 = player 1, 1 = player 2 (valid with game_over)
//   hit1/hit2  out  one-cycle paddle hit pulses (only with PADDLE_HIT_EN)
//
// Optional feature macro: PADDLE_HIT_EN adds the hit1/hit2 outputs.
// -----------------------------------------------------------------------------
module pong_referee #(
    parameter int XSCREEN    = 160,
    parameter int PADDLE_LEN = 25,
    parameter int BALL_SIZE  = 5,
    parameter int SCORE_W    = 4,
    parameter int WIN_SCORE  = 9,
    parameter int HOLD_CYC   = 50000000
) (
    input  logic               CLOCK_50,
    input  logic               Resetn,
    input  logic [7:0]         X,
    input  logic [6:0]         Y,
    input  logic [6:0]         Y1,
    input  logic [6:0]         Y2,
    input  logic               new_game,
    output logic               miss1,
    output logic               miss2,
    output logic [SCORE_W-1:0] score1,
    output logic [SCORE_W-1:0] score2,
    output logic               serve,
    output logic               game_over,
    output logic               winner
`ifdef PADDLE_HIT_EN
    ,
    output logic               hit1,
    output logic               hit2
`endif
);

    localparam logic [7:0]         X_RIGHT   = 8'(XSCREEN);
    localparam logic [7:0]         PAD_LEN   = 8'(PADDLE_LEN);
    localparam logic [7:0]         BALL_H    = 8'(BALL_SIZE);
    localparam logic [SCORE_W-1:0] WIN       = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] SCORE_ONE = SCORE_W'(1);
    localparam logic [31:0]        HOLD_LOAD = 32'(HOLD_CYC - 1);

    typedef enum logic [1:0] {
        PLAY  = 2'd0,
        POINT = 2'd1,
        OVER  = 2'd2
    } state_t;

    state_t state, state_next;

    logic [7:0]         x_prev;
    logic [31:0]        count, count_next;
    logic [SCORE_W-1:0] score1_next, score2_next;
    logic [SCORE_W-1:0] score1_inc, score2_inc;
    logic               miss1_next, miss2_next, serve_next;
    logic               game_over_next, winner_next;
    logic               left_evt, right_evt;
    logic               ovl1, ovl2;
    logic               left_miss, right_miss;
`ifdef PADDLE_HIT_EN
    logic               hit1_next, hit2_next;
`endif

    // Edge events fire only on arrival, so a ball parked on an edge counts
    // once. A coincident right event (XSCREEN==0) is dropped in favour of left.
    assign left_evt  = (X == 8'd0) && (x_prev != 8'd0);
    assign right_evt = (X == X_RIGHT) && (x_prev != X_RIGHT) && !left_evt;

    // 8-bit unsigned overlap: Y <= 127 and paddle/ball sizes keep sums in range.
    assign ovl1 = (({1'b0, Y} + BALL_H) > {1'b0, Y1}) && ({1'b0, Y} < ({1'b0, Y1} + PAD_LEN));
    assign ovl2 = (({1'b0, Y} + BALL_H) > {1'b0, Y2}) && ({1'b0, Y} < ({1'b0, Y2} + PAD_LEN));

    assign left_miss  = left_evt && !ovl1;
    assign right_miss = right_evt && !ovl2;

    assign score1_inc = score1 + SCORE_ONE;
    assign score2_inc = score2 + SCORE_ONE;

    // State register plus the registered outputs and datapath.
    always_ff @(posedge CLOCK_50) begin
        if (!Resetn) begin
            state     <= PLAY;
            x_prev    <= 8'd0;
            count     <= 32'd0;
            score1    <= '0;
            score2    <= '0;
            miss1     <= 1'b0;
            miss2     <= 1'b0;
            serve     <= 1'b0;
            game_over <= 1'b0;
            winner    <= 1'b0;
`ifdef PADDLE_HIT_EN
            hit1      <= 1'b0;
            hit2      <= 1'b0;
`endif
        end else begin
            state     <= state_next;
            x_prev    <= X;
            count     <= count_next;
            score1    <= score1_next;
            score2    <= score2_next;
            miss1     <= miss1_next;
            miss2     <= miss2_next;
            serve     <= serve_next;
            game_over <= game_over_next;
            winner    <= winner_next;
`ifdef PADDLE_HIT_EN
            hit1      <= hit1_next;
            hit2      <= hit2_next;
`endif
        end
    end

    // Next-state logic. A winning miss goes straight to OVER and skips the
    // pause; new_game overrides everything else.
    always_comb begin
        state_next = state;
        case (state)
            PLAY: begin
                if (left_miss) begin
                    state_next = (score2_inc == WIN) ? OVER : POINT;
                end else if (right_miss) begin
                    state_next = (score1_inc == WIN) ? OVER : POINT;
                end
            end
            POINT: begin
                if (count == 32'd0) begin
                    state_next = PLAY;
                end
            end
            OVER: begin
                state_next = OVER;
            end
            default: begin
                state_next = PLAY;
            end
        endcase
        if (new_game) begin
            state_next = PLAY;
        end
    end

    // Output / datapath logic. Pulses default low so each lasts one cycle.
    always_comb begin
        score1_next    = score1;
        score2_next    = score2;
        count_next     = count;
        miss1_next     = 1'b0;
        miss2_next     = 1'b0;
        serve_next     = 1'b0;
        game_over_next = game_over;
        winner_next    = winner;
`ifdef PADDLE_HIT_EN
        hit1_next      = 1'b0;
        hit2_next      = 1'b0;
`endif
        case (state)
            PLAY: begin
                if (left_miss) begin
                    miss1_next  = 1'b1;
                    score2_next = score2_inc;
                    if (score2_inc == WIN) begin
                        game_over_next = 1'b1;
                        winner_next    = 1'b1;
                    end else begin
                        count_next = HOLD_LOAD;
                    end
                end else if (right_miss) begin
                    miss2_next  = 1'b1;
                    score1_next = score1_inc;
                    if (score1_inc == WIN) begin
                        game_over_next = 1'b1;
                        winner_next    = 1'b0;
                    end else begin
                        count_next = HOLD_LOAD;
                    end
                end
`ifdef PADDLE_HIT_EN
                hit1_next = left_evt && ovl1;
                hit2_next = right_evt && ovl2;
`endif
            end
            POINT: begin
                if (count == 32'd0) begin
                    serve_next = 1'b1;
                end else begin
                    count_next = count - 32'd1;
                end
            end
            default: begin
            end
        endcase
        if (new_game) begin
            score1_next    = '0;
            score2_next    = '0;
            count_next     = 32'd0;
            miss1_next     = 1'b0;
            miss2_next     = 1'b0;
            serve_next     = 1'b0;
            game_over_next = 1'b0;
            winner_next    = 1'b0;
`ifdef PADDLE_HIT_EN
            hit1_next      = 1'b0;
            hit2_next      = 1'b0;
`endif
        end
    end

endmodule

// File: tb/tb_pong_referee.sv
// -----------------------------------------------------------------------------
// tb_pong_referee
// Self-checking bench for pong_referee with a small hold time and a short
// match. A behavioural referee model (scores, pause age, match flag) predicts
// every output after each clock edge.
// -----------------------------------------------------------------------------
module tb_pong_referee;

    localparam int XS = 160;
    localparam int PL = 25;
    localparam int BS = 5;
    localparam int SW = 4;
    localparam int WS = 3;
    localparam int HC = 4;
`ifdef PADDLE_HIT_EN
    localparam bit HITS = 1'b1;
`else
    localparam bit HITS = 1'b0;
`endif

    logic          CLOCK_50 = 1'b0;
    logic          Resetn   = 1'b0;
    logic [7:0]    X        = 8'd0;
    logic [6:0]    Y        = 7'd0;
    logic [6:0]    Y1       = 7'd0;
    logic [6:0]    Y2       = 7'd0;
    logic          new_game = 1'b0;
    logic          miss1, miss2, serve, game_over, winner;
    logic [SW-1:0] score1, score2;
    logic          hit1, hit2;
    logic [14:0]   obs;

    int checks = 0;
    int errors = 0;

    // Behavioural model of the referee.
    int m_x_prev, m_s1, m_s2, m_age;
    bit m_over, m_win, m_pause;
    bit m_miss1, m_miss2, m_serve, m_hit1, m_hit2;

    pong_referee #(
        .XSCREEN(XS), .PADDLE_LEN(PL), .BALL_SIZE(BS),
        .SCORE_W(SW), .WIN_SCORE(WS), .HOLD_CYC(HC)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .Resetn   (Resetn),
        .X        (X),
        .Y        (Y),
        .Y1       (Y1),
        .Y2       (Y2),
        .new_game (new_game),
        .miss1    (miss1),
        .miss2    (miss2),
        .score1   (score1),
        .score2   (score2),
        .serve    (serve),
        .game_over(game_over),
`ifdef PADDLE_HIT_EN
        .winner   (winner),
        .hit1     (hit1),
        .hit2     (hit2)
`else
        .winner   (winner)
`endif
    );

`ifndef PADDLE_HIT_EN
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    assign obs = {hit1, hit2, miss1, miss2, serve, game_over, winner, score1, score2};

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [14:0] exp_vec();
        return {m_hit1, m_hit2, m_miss1, m_miss2, m_serve, m_over, m_win, 4'(m_s1), 4'(m_s2)};
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        bit l, r;
        m_miss1 = 0; m_miss2 = 0; m_serve = 0; m_hit1 = 0; m_hit2 = 0;
        if (!Resetn) begin
            m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0; m_pause = 0; m_age = 0;
            m_x_prev = 0;
            return;
        end
        if (new_game) begin
            m_s1 = 0; m_s2 = 0; m_over = 0; m_win = 0; m_pause = 0; m_age = 0;
            m_x_prev = int'(X);
            return;
        end
        l = (X == 0) && (m_x_prev != 0);
        r = (X == XS) && (m_x_prev != XS) && !l;
        if (m_over) begin
            // match decided: nothing changes
        end else if (m_pause) begin
            m_age++;
            if (m_age == HC) begin
                m_serve = 1;
                m_pause = 0;
            end
        end else if (l) begin
            if ((int'(Y) + BS > int'(Y1)) && (int'(Y) < int'(Y1) + PL)) begin
                m_hit1 = HITS;
            end else begin
                m_miss1 = 1;
                m_s2++;
                if (m_s2 == WS) begin m_over = 1; m_win = 1; end
                else begin m_pause = 1; m_age = 0; end
            end
        end else if (r) begin
            if ((int'(Y) + BS > int'(Y2)) && (int'(Y) < int'(Y2) + PL)) begin
                m_hit2 = HITS;
            end else begin
                m_miss2 = 1;
                m_s1++;
                if (m_s1 == WS) begin m_over = 1; m_win = 0; end
                else begin m_pause = 1; m_age = 0; end
            end
        end
        m_x_prev = int'(X);
    endtask

    task automatic tick();
        @(posedge CLOCK_50);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        Resetn = 0; new_game = 1; X = 8'd0;
        tick(); tick();
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_outputs: got %h expected %h", obs, 15'd0);
        end
        Resetn = 1; new_game = 0;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL reset_release: got %h expected %h", obs, exp_vec());
        end
    endtask

    task automatic test_miss_serve();
        int serve_at = -1;
        int misses = 0;
        Y = 7'd50; Y1 = 7'd10; Y2 = 7'd0; X = 8'd5;
        tick();
        X = 8'd0;
        tick();
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL miss_edge: got %h expected %h", obs, exp_vec());
        end
        checks++;
        if (miss1 !== 1'b1 || score2 !== 4'd1) begin
            errors++;
            $display("[TB] FAIL miss1_score2: got miss1=%b score2=%0d expected 1 and 1", miss1, score2);
        end
        misses += int'(miss1);
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL point_cycle%0d: got %h expected %h", i, obs, exp_vec());
            end
            misses += int'(miss1);
            if (serve === 1'b1 && serve_at < 0) serve_at = i;
        end
        checks++;
        if (serve_at != HC - 1 || misses != 1) begin
            errors++;
            $display("[TB] FAIL serve_timing: got serve_at=%0d misses=%0d expected %0d and 1", serve_at, misses, HC - 1);
        end
    endtask

    task automatic test_hit();
        int hits = 0;
        int misses = 0;
        new_game = 1; tick(); new_game = 0;
        Y = 7'd20; Y1 = 7'd10; X = 8'd5;
        tick();
        X = 8'd0;
        for (int i = 0; i < 10; i++) begin
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL hit_cycle%0d: got %h expected %h", i, obs, exp_vec());
            end
            hits += int'(hit1);
            misses += int'(miss1);
        end
        checks++;
        if (misses != 0 || hits != int'(HITS) || score1 !== 4'd0 || score2 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL hit_summary: got misses=%0d hits=%0d s1=%0d s2=%0d expected 0 %0d 0 0",
                     misses, hits, score1, score2, HITS);
        end
    endtask

    task automatic test_match_over();
        bit seen;
        new_game = 1; tick(); new_game = 0;
        Y = 7'd100; Y1 = 7'd10; Y2 = 7'd0;
        for (int k = 0; k < 3; k++) begin
            X = 8'd5; tick();
            X = 8'(XS); tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL right_miss%0d: got %h expected %h", k, obs, exp_vec());
            end
            if (k < 2) begin
                seen = 0;
                for (int i = 0; i < 10 && !seen; i++) begin
                    tick();
                    seen = (serve === 1'b1);
                end
                checks++;
                if (!seen) begin
                    errors++;
                    $display("[TB] FAIL serve_wait%0d: got no serve expected serve within 10 cycles", k);
                end
            end
        end
        checks++;
        if (score1 !== 4'd3 || game_over !== 1'b1 || winner !== 1'b0) begin
            errors++;
            $display("[TB] FAIL match_won: got s1=%0d over=%b winner=%b expected 3 1 0", score1, game_over, winner);
        end
        X = 8'd5; tick();
        X = 8'(XS); tick();
        X = 8'd0; tick();
        checks++;
        if (obs !== exp_vec() || score1 !== 4'd3 || score2 !== 4'd0) begin
            errors++;
            $display("[TB] FAIL over_ignores: got %h expected %h", obs, exp_vec());
        end
        new_game = 1; X = 8'(XS); tick(); new_game = 0;
        checks++;
        if (score1 !== 4'd0 || score2 !== 4'd0 || game_over !== 1'b0) begin
            errors++;
            $display("[TB] FAIL new_game_clear: got s1=%0d s2=%0d over=%b expected 0 0 0", score1, score2, game_over);
        end
    endtask

    task automatic test_reset_in_point();
        int serves = 0;
        new_game = 1; tick(); new_game = 0;
        Y = 7'd50; Y1 = 7'd10;
        for (int k = 0; k < 2; k++) begin
            X = 8'd5; tick();
            X = 8'd0; tick();
            if (k == 0) for (int i = 0; i < HC + 1; i++) tick();
        end
        tick();
        checks++;
        if (score2 !== 4'd2 || obs !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL pre_reset_point: got %h expected %h", obs, exp_vec());
        end
        Resetn = 0; tick(); Resetn = 1;
        checks++;
        if (obs !== 15'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_point: got %h expected %h", obs, 15'd0);
        end
        for (int i = 0; i < HC + 3; i++) begin
            tick();
            serves += int'(serve);
        end
        checks++;
        if (serves != 0 || obs !== exp_vec()) begin
            errors++;
            $display("[TB] FAIL no_serve_after_reset: got serves=%0d vec=%h expected 0 %h", serves, obs, exp_vec());
        end
    endtask

    task automatic test_boundary();
        logic [6:0] ys [3] = '{7'd5, 7'd34, 7'd35};
        logic       em [3] = '{1'b1, 1'b0, 1'b1};
        Y1 = 7'd10;
        for (int k = 0; k < 3; k++) begin
            Y = ys[k];
            new_game = 1; X = 8'd5; tick();
            new_game = 0; X = 8'd0; tick();
            checks++;
            if (miss1 !== em[k] || obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL boundary_y%0d: got miss1=%b vec=%h expected %b %h", ys[k], miss1, obs, em[k], exp_vec());
            end
        end
    endtask

    task automatic test_random();
        int sel;
        for (int i = 0; i < 600; i++) begin
            Resetn   = ($urandom_range(0, 99) != 0);
            new_game = ($urandom_range(0, 59) == 0);
            sel = $urandom_range(0, 3);
            case (sel)
                0: X = 8'd0;
                1: X = 8'(XS);
                2: X = X;
                default: X = 8'($urandom_range(0, 255));
            endcase
            Y  = 7'($urandom_range(0, 127));
            Y1 = 7'($urandom_range(0, 127));
            Y2 = 7'($urandom_range(0, 127));
            tick();
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("[TB] FAIL random_cycle%0d: got %h expected %h", i, obs, exp_vec());
            end
        end
        Resetn = 1; new_game = 0;
    endtask

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_miss_serve();
        test_hit();
        test_match_over();
        test_reset_in_point();
        test_boundary();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
